// File: rtl/uart_wb_pkg.sv
// Shared command/response codes and FSM state type for the UART-to-Wishbone bridge.
// The optional ack timeout is enabled with the UART_WB_TIMEOUT_EN macro in uart_wb_bridge.
package uart_wb_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RESP_OK   = 8'h4B;
  localparam logic [7:0] RESP_ERR  = 8'h45;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_DATA     = 3'd2,
    ST_REQ      = 3'd3,
    ST_WAIT_ACK = 3'd4,
    ST_RESP     = 3'd5
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_wb_resp_ser.sv
// Byte serialiser for bridge responses: loads an N-byte word plus a byte count and
// sends the top bytes MSB first over a valid/ready stream.
module uart_wb_resp_ser #(
  parameter int unsigned N_BYTES = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_load,
  input  logic [8*N_BYTES-1:0]           i_word,
  input  logic [$clog2(N_BYTES+1)-1:0]   i_count,
  output logic [7:0]                     o_tx_data,
  output logic                           o_tx_valid,
  input  logic                           i_tx_ready,
  output logic                           o_last
);

  localparam int unsigned W  = 8 * N_BYTES;
  localparam int unsigned CW = $clog2(N_BYTES + 1);

  // Handshake: a byte moves only on a cycle with o_tx_valid & i_tx_ready;
  // o_tx_data holds its value on every other cycle while valid is high.
  logic [W-1:0]  shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fire;

  assign o_tx_valid = (cnt_q != '0);
  assign fire       = o_tx_valid & i_tx_ready;
  assign o_last     = fire & (cnt_q == CW'(1));
  assign o_tx_data  = shift_q[W-1 -: 8];

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (i_load) begin
      shift_d = i_word;
      cnt_d   = i_count;
    end else if (fire) begin
      shift_d = shift_q << 8;
      cnt_d   = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_wb_bridge.sv
// UART byte-stream to Wishbone master bridge: parses W/R frames, issues one Wishbone
// cycle, answers with 'K' or read data. Define UART_WB_TIMEOUT_EN for the ack timeout.
module uart_wb_bridge
  import uart_wb_pkg::*;
#(
  parameter int unsigned WB_ADDR_BITS   = 32,
  parameter int unsigned WB_DATA_BITS   = 32,
  parameter int unsigned AUX_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                      i_controller_clk,
  input  logic                      i_rst_n,
  input  logic [7:0]                i_rx_data,
  input  logic                      i_rx_valid,
  output logic [7:0]                o_tx_data,
  output logic                      o_tx_valid,
  input  logic                      i_tx_ready,
  output logic                      o_wb_cyc,
  output logic                      o_wb_stb,
  output logic                      o_wb_we,
  output logic [WB_ADDR_BITS-1:0]   o_wb_addr,
  output logic [WB_DATA_BITS-1:0]   o_wb_data,
  output logic [WB_DATA_BITS/8-1:0] o_wb_sel,
  output logic [AUX_WIDTH-1:0]      o_aux,
  input  logic                      i_wb_stall,
  input  logic                      i_wb_ack,
  input  logic [WB_DATA_BITS-1:0]   i_wb_data,
  input  logic [AUX_WIDTH-1:0]      i_aux,
  output logic                      o_overrun,
  output logic                      o_busy,
  output state_e                    o_dbg_state
);

  localparam int unsigned AB    = WB_ADDR_BITS / 8;
  localparam int unsigned DB    = WB_DATA_BITS / 8;
  localparam int unsigned CNT_W = $clog2(max_u(AB, DB) + 1);
  localparam int unsigned RCW   = $clog2(DB + 1);

  if ((WB_ADDR_BITS % 8) != 0 || WB_ADDR_BITS < 8 || WB_ADDR_BITS > 64 ||
      (WB_DATA_BITS % 8) != 0 || WB_DATA_BITS < 8 || WB_DATA_BITS > 128 ||
      AUX_WIDTH < 4 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("uart_wb_bridge: parameter out of range");
  end

  // Reset asserts immediately but releases two clocks after i_rst_n rises.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n      = rst_sync_q[1];

  always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= rst_sync_d;
  end

  state_e                  state_q, state_d;
  logic                    we_q, we_d;
  logic [WB_ADDR_BITS-1:0] addr_q, addr_d;
  logic [WB_DATA_BITS-1:0] data_q, data_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    overrun_q, overrun_d;

  logic                    ser_load;
  logic [WB_DATA_BITS-1:0] ser_word;
  logic [RCW-1:0]          ser_count;
  logic [7:0]              ser_data;
  logic                    ser_valid;
  logic                    ser_last;

  logic                    ack_take;
  logic                    tmo_fire;
  logic                    unused_aux;

  // Single-byte responses sit in the top byte so the serialiser sends them first.
  localparam logic [WB_DATA_BITS-1:0] OK_WORD  = WB_DATA_BITS'(RESP_OK)  << (WB_DATA_BITS - 8);
  localparam logic [WB_DATA_BITS-1:0] ERR_WORD = WB_DATA_BITS'(RESP_ERR) << (WB_DATA_BITS - 8);

  assign unused_aux = ^i_aux;
  assign ack_take   = i_wb_ack &&
                      ((state_q == ST_WAIT_ACK) || (state_q == ST_REQ && !i_wb_stall));

`ifdef UART_WB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             in_txn;

  assign in_txn   = (state_q == ST_REQ) || (state_q == ST_WAIT_ACK);
  assign tmo_fire = in_txn && !ack_take && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = '0;
    if (in_txn) tmo_d = tmo_q + TMO_W'(1);
  end

  always_ff @(posedge i_controller_clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    overrun_d = 1'b0;
    ser_load  = 1'b0;
    ser_word  = '0;
    ser_count = '0;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_valid && (i_rx_data == CMD_WRITE || i_rx_data == CMD_READ)) begin
          we_d    = (i_rx_data == CMD_WRITE);
          cnt_d   = '0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (i_rx_valid) begin
          addr_d = (addr_q << 8) | WB_ADDR_BITS'(i_rx_data);
          if (cnt_q == CNT_W'(AB - 1)) begin
            cnt_d   = '0;
            state_d = we_q ? ST_DATA : ST_REQ;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (i_rx_valid) begin
          data_d = (data_q << 8) | WB_DATA_BITS'(i_rx_data);
          if (cnt_q == CNT_W'(DB - 1)) begin
            cnt_d   = '0;
            state_d = ST_REQ;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_REQ, ST_WAIT_ACK: begin
        overrun_d = i_rx_valid;
        if (ack_take) begin
          state_d  = ST_RESP;
          ser_load = 1'b1;
          if (we_q) begin
            ser_word  = OK_WORD;
            ser_count = RCW'(1);
          end else begin
            ser_word  = i_wb_data;
            ser_count = RCW'(DB);
          end
        end else if (tmo_fire) begin
          state_d   = ST_RESP;
          ser_load  = 1'b1;
          ser_word  = ERR_WORD;
          ser_count = RCW'(1);
        end else if (state_q == ST_REQ && !i_wb_stall) begin
          state_d = ST_WAIT_ACK;
        end
      end
      ST_RESP: begin
        overrun_d = i_rx_valid;
        if (ser_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_controller_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  uart_wb_resp_ser #(.N_BYTES(DB)) u_resp_ser (
    .clk        (i_controller_clk),
    .rst_n      (rst_n),
    .i_load     (ser_load),
    .i_word     (ser_word),
    .i_count    (ser_count),
    .o_tx_data  (ser_data),
    .o_tx_valid (ser_valid),
    .i_tx_ready (i_tx_ready),
    .o_last     (ser_last)
  );

  assign o_wb_cyc    = (state_q == ST_REQ) || (state_q == ST_WAIT_ACK);
  assign o_wb_stb    = (state_q == ST_REQ);
  assign o_wb_we     = we_q & o_wb_cyc;
  assign o_wb_addr   = addr_q;
  assign o_wb_data   = data_q;
  assign o_wb_sel    = {(WB_DATA_BITS/8){o_wb_stb}};
  assign o_aux       = o_wb_stb ? AUX_WIDTH'(we_q) : '0;
  assign o_tx_valid  = ser_valid & (state_q == ST_RESP);
  assign o_tx_data   = ser_data;
  assign o_overrun   = overrun_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_dbg_state = state_q;

endmodule

// File: doc/uart_wb_bridge.md
UART_WB_BRIDGE -- requirements
Module: uart_wb_bridge

Interface
REQ-001 SHALL have parameter WB_ADDR_BITS, default 32: Wishbone address width, multiple of 8, range 8..64.
REQ-002 SHALL have parameter WB_DATA_BITS, default 32: Wishbone data width, multiple of 8, range 8..128.
REQ-003 SHALL have parameter AUX_WIDTH, default 4: aux width, at least 4.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 65535: ack timeout in clocks, at least 1.
REQ-005 SHALL have port i_controller_clk, input, 1 bit: the single clock; all logic rises on its edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have ports i_rx_data (in, 8) and i_rx_valid (in, 1): received UART byte stream; the bridge applies no backpressure.
REQ-008 SHALL have ports o_tx_data (out, 8), o_tx_valid (out, 1) and i_tx_ready (in, 1): response byte stream.
REQ-009 SHALL have Wishbone master outputs o_wb_cyc (1), o_wb_stb (1), o_wb_we (1), o_wb_addr (WB_ADDR_BITS), o_wb_data (WB_DATA_BITS), o_wb_sel (WB_DATA_BITS/8) and o_aux (AUX_WIDTH).
REQ-010 SHALL have Wishbone master inputs i_wb_stall (1), i_wb_ack (1), i_wb_data (WB_DATA_BITS) and i_aux (AUX_WIDTH).
REQ-011 SHALL have status outputs o_overrun (out, 1): one-cycle pulse per dropped byte; o_busy (out, 1): high whenever state is not IDLE.

Function
REQ-012 Frame formats: write = 0x57 ('W'), AB address bytes, DB data bytes; read = 0x52 ('R'), AB address bytes; AB=WB_ADDR_BITS/8, DB=WB_DATA_BITS/8; all fields MSB byte first.
REQ-013 States SHALL be IDLE, ADDR, DATA, REQ, WAIT_ACK, RESP.
REQ-014 In IDLE, 0x57 or 0x52 SHALL latch the direction, clear the byte counter and go to ADDR; any other byte SHALL be discarded silently.
REQ-015 In ADDR, each valid byte SHALL shift into the address register. After byte AB, a write SHALL go to DATA and a read SHALL go to REQ.
REQ-016 In DATA, each valid byte SHALL shift into the data register; after byte DB the state SHALL go to REQ.
REQ-017 In REQ, o_wb_cyc and o_wb_stb SHALL be 1, with o_wb_sel all ones and o_aux = {zeros, we}.
REQ-018 In REQ, stb SHALL remain high until a cycle with i_wb_stall=0; that cycle is the accepted request, after which stb drops and the state goes to WAIT_ACK with cyc still high.
REQ-019 In WAIT_ACK, i_wb_ack=1 SHALL drop cyc and go to RESP. A read SHALL capture i_wb_data; a write SHALL load a single response byte 0x4B ('K'). An ack in the same cycle as stb acceptance SHALL be honoured.
REQ-020 In RESP, the read data SHALL be sent MSB byte first, DB bytes. Each byte advances only on o_tx_valid & i_tx_ready, and o_tx_data stays stable while stalled. After the last byte the state SHALL return to IDLE.
REQ-021 Minimum latency from the last frame byte to o_wb_stb=1 SHALL be 1 clock.
REQ-022 A valid rx byte received in REQ, WAIT_ACK or RESP SHALL be dropped and SHALL pulse o_overrun on the next cycle.
REQ-023 The byte counter SHALL be $clog2(max(AB,DB)+1) bits wide and SHALL never wrap within a frame.
REQ-024 o_tx_valid SHALL be 0 outside RESP.

Reset
REQ-025 While i_rst_n=0, the state SHALL be IDLE and all outputs SHALL be 0, including address, data, counter and timeout counter; this applies immediately and asynchronously.
REQ-026 Reset deassertion SHALL be synchronised internally through a two-flop release.
REQ-027 Reset mid-frame or mid-transaction SHALL abandon the transaction with no response byte; the partial frame SHALL be lost.

Configuration
REQ-028 With macro UART_WB_TIMEOUT_EN defined, a counter SHALL run in REQ and WAIT_ACK.
REQ-029 Under UART_WB_TIMEOUT_EN, reaching TIMEOUT_CYCLES SHALL drop cyc and stb, send the single byte 0x45 ('E') and return to IDLE; a late ack after that SHALL be ignored.
REQ-030 Without UART_WB_TIMEOUT_EN, the bridge SHALL wait indefinitely, and no timeout counter logic SHALL be present.

Structure
REQ-031 Package uart_wb_pkg SHALL hold the command codes (0x57, 0x52), the response codes (0x4B, 0x45) and the state enum typedef.
REQ-032 Sub-module uart_wb_resp_ser SHALL be a parameterised byte serialiser taking a width-N word and a byte count and driving the tx handshake; it is instantiated once.

Verification
REQ-033 Write test: send 57 00 00 00 2A 11 22 33 44 -> one stb with addr=0x0000002A, data=0x11223344, we=1, sel=0xF; after ack, tx emits 4B.
REQ-034 Read test: send 52 00 00 00 2A with ack data 0xDEADBEEF -> tx emits DE AD BE EF in order.
REQ-035 Stall test: hold i_wb_stall=1 for 5 cycles -> stb and addr held stable for 6 cycles, exactly one accepted request.
REQ-036 Backpressure and overrun test: hold i_tx_ready=0 for 10 cycles during a read response while sending 41 -> o_tx_data stable, one o_overrun pulse, then all 4 bytes delivered.
REQ-037 Timeout test: with UART_WB_TIMEOUT_EN and TIMEOUT_CYCLES=16, never ack -> cyc drops after 16 cycles, tx emits 45, next 52 frame accepted.
REQ-038 Junk and reset test: send 00 FF 52 00, then pulse i_rst_n low -> junk bytes ignored, all outputs 0 during reset, no tx byte, state IDLE.
